// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write arbiter.
//   state_t  : arbiter FSM states (IDLE, BURST)
//   DEF_*    : default parameter values used by the top and the bench
//   idx_w()  : index width for a given number of requesters (at least 1 bit)
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_DEPTH     = 8;
  localparam int DEF_CNT_W     = 4;
  localparam int DEF_BURST_MAX = 4;
  localparam int STAT_W        = 16;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin pick: the first asserted req at or after rr_ptr, wrapping.
// Ports:
//   req    in   NUM_REQ  request vector
//   rr_ptr in   IW       index with highest priority this cycle
//   valid  out  1        any request present
//   idx    out  IW       chosen requester (rr_ptr when nothing requests)
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  output logic               valid,
  output logic [IW-1:0]      idx
);

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    int j;
    j     = 0;
    valid = 1'b0;
    idx   = rr_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(rr_ptr) + k) % NUM_REQ;
      if (req[j]) begin
        valid = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO among NUM_REQ producers.
// Grants bursts of up to BURST_MAX words and never overfills the FIFO,
// counting its own write that has not yet shown up in fifo_counter.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   req, req_data     producer requests and packed data (i at [i*DATA_W +: DATA_W])
//   gnt               one-hot, combinational: word taken from requester i this cycle
//   fifo_counter      FIFO occupancy; fifo_full FIFO full flag
//   fifo_wr/fifo_data registered FIFO write port (one cycle after gnt)
//   busy              high while a tenure is open (BURST)
// Optional build macro FIFO_ARB_STATS_EN adds:
//   stat_grants       per-requester saturating 16-bit granted-word counters
//   stat_stall        saturating count of cycles with any req and no space
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int BURST_MAX = DEF_BURST_MAX
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  input  logic [CNT_W-1:0]          fifo_counter,
  input  logic                      fifo_full,
  output logic                      fifo_wr,
  output logic [DATA_W-1:0]         fifo_data,
  output logic                      busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0] stat_grants,
  output logic [STAT_W-1:0]         stat_stall
`endif
);

  localparam int IW = idx_w(NUM_REQ);
  localparam int BW = $clog2(BURST_MAX + 1);

  state_t            state, state_nxt;
  logic [IW-1:0]     owner, owner_nxt;
  logic [IW-1:0]     rr_ptr, rr_ptr_nxt;
  logic [IW-1:0]     pick_idx, gnt_idx;
  logic [BW-1:0]     burst_cnt, burst_cnt_nxt;
  logic              pick_valid, space, take;
  logic [CNT_W:0]    occ_sum;
  logic [DATA_W-1:0] req_word [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_word[i] = req_data[i*DATA_W +: DATA_W];
  end

  // The registered fifo_wr is a word the FIFO has not counted yet.
  assign occ_sum = {1'b0, fifo_counter} + (CNT_W + 1)'(fifo_wr);
  assign space   = (occ_sum < (CNT_W + 1)'(DEPTH)) && !fifo_full;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .idx    (pick_idx)
  );

  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    rr_ptr_nxt    = rr_ptr;
    burst_cnt_nxt = burst_cnt;
    take          = 1'b0;
    gnt_idx       = owner;
    unique case (state)
      IDLE: begin
        if (pick_valid && space) begin
          take          = 1'b1;
          gnt_idx       = pick_idx;
          owner_nxt     = pick_idx;
          burst_cnt_nxt = BW'(1);
          state_nxt     = BURST;
        end
      end
      BURST: begin
        if (req[owner] && (burst_cnt < BW'(BURST_MAX))) begin
          // Without space the tenure is kept and simply stalls.
          if (space) begin
            take          = 1'b1;
            burst_cnt_nxt = burst_cnt + BW'(1);
          end
        end else begin
          rr_ptr_nxt = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + IW'(1);
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Reset must suppress the grant so no producer believes its word was taken.
    if (reset) take = 1'b0;
  end

  assign gnt  = take ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign busy = (state == BURST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      fifo_wr   <= 1'b0;
      fifo_data <= '0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      rr_ptr    <= rr_ptr_nxt;
      burst_cnt <= burst_cnt_nxt;
      fifo_wr   <= take;
      if (take) fifo_data <= req_word[gnt_idx];
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [STAT_W-1:0] grants_q [NUM_REQ];
  logic [STAT_W-1:0] stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) grants_q[i] <= '0;
      stall_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt[i] && (grants_q[i] != '1)) grants_q[i] <= grants_q[i] + STAT_W'(1);
      end
      if ((|req) && !space && (stall_q != '1)) stall_q <= stall_q + STAT_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
    assign stat_grants[i*STAT_W +: STAT_W] = grants_q[i];
  end
  assign stat_stall = stall_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int N     = DEF_NUM_REQ;
  localparam int DW    = DEF_DATA_W;
  localparam int DEPTH = DEF_DEPTH;
  localparam int CW    = DEF_CNT_W;
  localparam int BM    = DEF_BURST_MAX;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      gnt;
  logic [CW-1:0]     fifo_counter;
  logic              fifo_full;
  logic              fifo_wr;
  logic [DW-1:0]     fifo_data;
  logic              busy;
`ifdef FIFO_ARB_STATS_EN
  logic [N*16-1:0]   stat_grants;
  logic [15:0]       stat_stall;
`endif

  always #5 clk = ~clk;

  fifo_wr_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_data     (req_data),
    .gnt          (gnt),
    .fifo_counter (fifo_counter),
    .fifo_full    (fifo_full),
    .fifo_wr      (fifo_wr),
    .fifo_data    (fifo_data),
    .busy         (busy)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stat_grants  (stat_grants),
    .stat_stall   (stat_stall)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Environment: producers with a word budget (-1 = endless) and a FIFO occupancy.
  int          occ;
  int          rd_pct;
  bit          rnd_mode;
  int          words_left [N];
  logic [DW-1:0] pdata [N];

  // Reference model: current tenure holder (-1 = none), words in tenure, next priority.
  int          m_owner, m_words, m_ptr, m_idx;
  logic        m_wr;
  logic [DW-1:0] m_data;
  logic [N-1:0]  e_gnt;
  logic          e_busy;
  int            m_gr [N];
  int            m_stall;

  logic [N-1:0]  obs_gnt;
  logic          obs_wr;
  logic [DW-1:0] obs_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req[i] = (words_left[i] != 0);
      req_data[i*DW +: DW] = pdata[i];
    end
    fifo_counter = CW'(occ);
    fifo_full    = (occ >= DEPTH);
  endtask

  task automatic model_comb();
    bit space;
    space  = ((occ + int'(m_wr)) < DEPTH) && (occ < DEPTH);
    e_gnt  = '0;
    e_busy = (m_owner >= 0);
    m_idx  = -1;
    if (!reset) begin
      if (m_owner < 0) begin
        if (space) begin
          for (int k = N - 1; k >= 0; k--)
            if (req[(m_ptr + k) % N]) m_idx = (m_ptr + k) % N;
        end
      end else if (req[m_owner] && m_words < BM && space) begin
        m_idx = m_owner;
      end
      if (m_idx >= 0) e_gnt[m_idx] = 1'b1;
      if ((req != 0) && !space) m_stall++;
    end
  endtask

  task automatic model_seq();
    if (reset) begin
      m_owner = -1; m_words = 0; m_ptr = 0; m_wr = 1'b0; m_data = '0;
      m_stall = 0;
      for (int i = 0; i < N; i++) m_gr[i] = 0;
    end else begin
      m_wr = (m_idx >= 0);
      if (m_idx >= 0) begin
        m_data = pdata[m_idx];
        m_gr[m_idx]++;
      end
      if (m_owner < 0) begin
        if (m_idx >= 0) begin m_owner = m_idx; m_words = 1; end
      end else if (m_idx >= 0) begin
        m_words++;
      end else if (!req[m_owner] || m_words >= BM) begin
        m_ptr = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
  endtask

  task automatic env_seq(input bit rd, input bit wr_now);
    occ = occ + int'(wr_now) - int'(rd);
    chk("occupancy_bound", 64'(occ <= DEPTH && occ >= 0), 64'd1);
    for (int i = 0; i < N; i++) begin
      if (e_gnt[i]) begin
        if (words_left[i] > 0) words_left[i]--;
        pdata[i] = rnd_mode ? $urandom : pdata[i] + 1;
      end else if (rnd_mode && words_left[i] == 0 && $urandom_range(3) == 0) begin
        words_left[i] = $urandom_range(6, 1);
        pdata[i] = $urandom;
      end
    end
  endtask

  task automatic step();
    bit rd, wr_now;
    apply();
    #1;
    model_comb();
    obs_gnt = gnt; obs_wr = fifo_wr; obs_data = fifo_data;
    chk("gnt", 64'(gnt), 64'(e_gnt));
    chk("busy", 64'(busy), 64'(e_busy));
    chk("fifo_wr", 64'(fifo_wr), 64'(m_wr));
    chk("fifo_data", 64'(fifo_data), 64'(m_data));
    rd = (occ > 0) && ($urandom_range(99) < rd_pct);
    wr_now = m_wr;
    @(posedge clk);
    model_seq();
    env_seq(rd, wr_now);
    #1;
  endtask

  task automatic set_words(input int w0, input int w1, input int w2, input int w3);
    words_left[0] = w0; words_left[1] = w1; words_left[2] = w2; words_left[3] = w3;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) step();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] exp_g;
    int nw;
    rnd_mode = 1'b0; rd_pct = 100; occ = 0;
    m_wr = 1'b0; m_data = '0; m_owner = -1; m_words = 0; m_ptr = 0; m_stall = 0;
    for (int i = 0; i < N; i++) begin pdata[i] = DW'(32'h100 * (i + 1)); m_gr[i] = 0; end

    // 1. reset held with all requesting: no grant, no write, not busy
    set_words(-1, -1, -1, -1);
    reset = 1'b1;
    apply();
    @(posedge clk);
    model_seq();
    #1;
    for (int t = 0; t < 2; t++) begin
      step();
      chk("reset_gnt", 64'(obs_gnt), 64'd0);
      chk("reset_wr", 64'(obs_wr), 64'd0);
    end
    reset = 1'b0;
    step();
    chk("post_reset_gnt", 64'(obs_gnt), 64'b0001);

    // 2. single source, words A..E
    set_words(0, 0, 0, 0);
    do_reset(1);
    words_left[2] = 5;
    pdata[2] = 32'hA;
    nw = 0;
    for (int t = 0; t < 8; t++) begin
      step();
      exp_g = (t < 4 || t == 5) ? 4'b0100 : 4'b0000;
      chk("single_trace", 64'(obs_gnt), 64'(exp_g));
      if (obs_wr) begin
        chk("single_data", 64'(obs_data), 64'(32'hA + nw));
        nw++;
      end
    end
    chk("single_count", 64'(nw), 64'd5);

    // 3. round robin with fast drain
    set_words(-1, -1, -1, -1);
    do_reset(1);
    rd_pct = 100;
    for (int t = 0; t < 25; t++) begin
      step();
      exp_g = ((t % 5) < 4) ? N'(1 << ((t / 5) % N)) : '0;
      chk("rr_trace", 64'(obs_gnt), 64'(exp_g));
    end
`ifdef FIFO_ARB_STATS_EN
    chk("stat_g0", 64'(stat_grants[0 +: 16]), 64'd8);
    chk("stat_g1", 64'(stat_grants[16 +: 16]), 64'd4);
    chk("stat_g2", 64'(stat_grants[32 +: 16]), 64'd4);
    chk("stat_g3", 64'(stat_grants[48 +: 16]), 64'd4);
`endif
    // reset mid-burst
    step();
    do_reset(1);
    step();
    chk("reset_mid_wr", 64'(obs_wr), 64'd0);
`ifdef FIFO_ARB_STATS_EN
    do_reset(1);
    #1;
    chk("stat_clear_g", 64'(stat_grants), 64'd0);
    chk("stat_clear_s", 64'(stat_stall), 64'd0);
`endif

    // 4. full boundary
    set_words(-1, 0, 0, 0);
    do_reset(1);
    rd_pct = 0;
    occ = 7;
    step(); chk("full_first_gnt", 64'(obs_gnt), 64'b0001);
    step(); chk("full_inflight", 64'(obs_gnt), 64'd0);
    step(); chk("full_stall_gnt", 64'(obs_gnt), 64'd0);
    chk("full_stall_busy", 64'(busy), 64'd1);
    step(); chk("full_stall2", 64'(obs_gnt), 64'd0);
    occ = 6;
    step(); chk("full_resume", 64'(obs_gnt), 64'b0001);
    rd_pct = 100;
    occ = 0;

    // 5. early drop by owner 1 while 3 waits
    set_words(0, 0, 0, 0);
    do_reset(1);
    set_words(0, 2, 0, -1);
    step(); chk("drop_w1", 64'(obs_gnt), 64'b0010);
    step(); chk("drop_w2", 64'(obs_gnt), 64'b0010);
    step(); chk("drop_gap", 64'(obs_gnt), 64'd0);
    step(); chk("drop_next", 64'(obs_gnt), 64'b1000);

    // 6. randomized traffic against the model
    set_words(0, 0, 0, 0);
    do_reset(1);
    rnd_mode = 1'b1;
    occ = 0;
    for (int blk = 0; blk < 6; blk++) begin
      rd_pct = $urandom_range(80, 15);
      repeat (120) step();
    end
`ifdef FIFO_ARB_STATS_EN
    for (int i = 0; i < N; i++) chk("rand_stat_g", 64'(stat_grants[i*16 +: 16]), 64'(m_gr[i]));
    chk("rand_stat_s", 64'(stat_stall), 64'(m_stall));
`endif
    do_reset(1);
    step();
    chk("final_reset_wr", 64'(obs_wr), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
